lane_density_encoder: RTL and testbench
=======================================

# lane_density_encoder

Per-lane vehicle queue tracker that converts raw arrival/departure detector pulses from the four approaches into the 2-bit traffic-density codes Sa, Sb, Sc, Sd consumed by the adaptive traffic controller. It is the sensor-side producer of the controller's density inputs. It keeps a saturating queue count per lane and publishes quantized densities once per fixed sampling window. A one-cycle strobe marks each new sample.

## Interface
- QW, 6: queue counter width per lane, in bits.
- WINDOW, 16: sampling window length in clk cycles. Legal range 2..255.
- TH1, 4: queue value at or above which the code is 1.
- TH2, 10: queue value at or above which the code is 2.
- TH3, 20: queue value at or above which the code is 3.
- Parameter constraint: 0 < TH1 < TH2 < TH3 ≤ 2^QW−1.
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- car_in  input  4  arrival pulses, one per lane; bit0=a, bit1=b, bit2=c, bit3=d. A high bit on a clk edge is one vehicle.
- car_out  input  4  departure pulses; same lane mapping as car_in.
- Sa, Sb, Sc, Sd  output  2 each  registered density code for each lane.
- sample  output  1  high for exactly one cycle whenever Sa..Sd take a new sample.
- ovf  output  4  sticky per-lane saturation flags.

## Operation
- Queue update per lane, evaluated each cycle as q_next:
  - in=1, out=0: q+1, saturating at 2^QW−1.
  - in=0, out=1: q−1, floored at 0. A departure from an empty queue is ignored and raises no flag.
  - in=1, out=1: q unchanged, including when q=0 or q=max.
  - in=0, out=0: q unchanged.
- Overflow: when in=1, out=0 and q is already 2^QW−1, the lane's ovf bit sets. It stays set until reset.
- Window counter wcnt counts 0..WINDOW−1 and wraps back to 0.
- Sample: on the edge where wcnt==WINDOW−1, each S output loads quant(q_next) and sample is set to 1.
  - q_next includes the arrival/departure presented in that same cycle.
  - On every other edge, sample is 0 and the S outputs hold.
- quant(q): 0 if q<TH1; 1 if TH1≤q<TH2; 2 if TH2≤q<TH3; 3 if q≥TH3.
- Lanes are fully independent. Events on one lane never affect another lane's queue, code or flag.
- No FSM beyond wcnt. The datapath is 4 × (QW-bit counter + comparator bank) plus one shared window counter.

## Timing
- Reset (rst_n low, asynchronous): all queues=0, wcnt=0, Sa..Sd=2'b00, sample=0, ovf=4'b0000.
- Reset asserted mid-window discards all counts immediately, with no sample strobe. Counting restarts from wcnt=0 after release.
- First sample: on the WINDOW-th rising edge after rst_n deasserts. Subsequent samples every WINDOW edges.
- Latency: an arrival on the sampling edge is already reflected in that sample. Between samples, S outputs lag the queue by up to WINDOW−1 cycles.
- sample and the new S values become visible together, registered from the same edge. Consumers may capture S on any cycle; the values are stable for the whole window.
- Inputs are synchronous to clk. Detector synchronization and debouncing are done upstream.

## Test plan
- Reset/idle: hold rst_n low, then release with no pulses for 3 windows.
  - Required: S=0 throughout; sample pulses at edges 16, 32 and 48; ovf=0.
- Threshold walk on lane a: single car_in[0] pulses, 10 total, all within the first window.
  - Required: first sample Sa=2 (10 ≥ TH2); Sb=Sc=Sd=0.
  - Then 7 car_out[0] pulses: next sample Sa=0 (3 < TH1).
- Boundary: car_in[2] pulse timed on the sampling edge itself, taking queue c from 3 to 4.
  - Required: Sc=1 in that same sample.
- Simultaneous events: car_in[1] and car_out[1] high together, at q=0 and again at q=63.
  - Required: queue unchanged both times; ovf[1] stays 0.
  - Then car_out[3] alone at q=0: queue stays 0, Sd=0.
- Saturation: 70 car_in[3] pulses.
  - Required: queue d=63, Sd=3, ovf[3]=1 and remains 1 after the queue drains to 0.
  - Other lanes' ovf bits stay 0.
- Mid-window reset: load lane a to 15, then pulse rst_n low at wcnt=9.
  - Required: immediate S=0, ovf=0, no sample.
  - Next sample exactly 16 edges after release, with Sa=0.

Source files
------------

// File: rtl/lane_density_encoder_if.sv
// lane_density_encoder_if: detector pulses in, density codes, sample strobe and overflow flags out
interface lane_density_encoder_if;
    logic [3:0] car_in;
    logic [3:0] car_out;
    logic [1:0] Sa;
    logic [1:0] Sb;
    logic [1:0] Sc;
    logic [1:0] Sd;
    logic       sample;
    logic [3:0] ovf;
    modport master (output car_in, car_out, input Sa, Sb, Sc, Sd, sample, ovf);
    modport slave  (input car_in, car_out, output Sa, Sb, Sc, Sd, sample, ovf);
endinterface

// File: rtl/lane_density_encoder.sv
// lane_density_encoder: saturating per-lane queue counts quantized into 2-bit density codes once per window
module lane_density_encoder #(
    parameter int QW     = 6,
    parameter int WINDOW = 16,
    parameter int TH1    = 4,
    parameter int TH2    = 10,
    parameter int TH3    = 20
) (
    input logic clk,
    input logic rst_n,
    lane_density_encoder_if.slave bus
);
    localparam int WW = $clog2(WINDOW);
    localparam logic [WW-1:0] WLAST = WW'(WINDOW - 1);
    localparam logic [QW-1:0] QMAX = '1;
    logic [WW-1:0] wcnt;
    logic          wrap;
    logic [3:0]    ovf_set;
    logic [1:0]    codes [4];
    assign wrap = wcnt == WLAST;
    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [QW-1:0] q, q_next;
        logic [1:0]    code, s;
        logic          inc, dec;
        assign inc        = bus.car_in[i] & ~bus.car_out[i];
        assign dec        = bus.car_out[i] & ~bus.car_in[i] & (q != '0);
        assign ovf_set[i] = inc & (q == QMAX);
        assign q_next     = (inc && q != QMAX) ? q + QW'(1) : dec ? q - QW'(1) : q;
        assign code       = (q_next >= QW'(TH3)) ? 2'd3 :
                            (q_next >= QW'(TH2)) ? 2'd2 :
                            (q_next >= QW'(TH1)) ? 2'd1 : 2'd0;
        assign codes[i]   = s;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= '0;
                s <= 2'd0;
            end else begin
                q <= q_next;
                if (wrap) s <= code;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt       <= '0;
            bus.sample <= 1'b0;
            bus.ovf    <= 4'b0000;
        end else begin
            wcnt       <= wrap ? '0 : wcnt + WW'(1);
            bus.sample <= wrap;
            bus.ovf    <= bus.ovf | ovf_set;
        end
    end
    assign bus.Sa = codes[0];
    assign bus.Sb = codes[1];
    assign bus.Sc = codes[2];
    assign bus.Sd = codes[3];
endmodule

// File: tb/tb_lane_density_encoder.sv
// tb_lane_density_encoder: directed test-plan scenarios plus random traffic against an edge-counting queue model
module tb_lane_density_encoder;
    logic clk = 0;
    logic rst_n = 0;
    int errors = 0;
    int checks = 0;
    lane_density_encoder_if bus();
    lane_density_encoder dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;
    int mq [4];
    int ms [4];
    bit m_sample;
    bit [3:0] m_ovf;
    int edges;
    function automatic int quant(input int q);
        return q >= 20 ? 3 : q >= 10 ? 2 : q >= 4 ? 1 : 0;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < 4; l++) begin
                mq[l] = 0;
                ms[l] = 0;
            end
            m_sample = 0;
            m_ovf = 0;
            edges = 0;
        end else begin
            edges++;
            for (int l = 0; l < 4; l++) begin
                if (bus.car_in[l] && !bus.car_out[l]) begin
                    if (mq[l] == 63) m_ovf[l] = 1;
                    else mq[l]++;
                end else if (!bus.car_in[l] && bus.car_out[l] && mq[l] > 0) begin
                    mq[l]--;
                end
            end
            m_sample = (edges % 16) == 0;
            if (m_sample)
                for (int l = 0; l < 4; l++) ms[l] = quant(mq[l]);
        end
    end
    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_Sa", 32'(bus.Sa), 32'(ms[0]));
            chk("model_Sb", 32'(bus.Sb), 32'(ms[1]));
            chk("model_Sc", 32'(bus.Sc), 32'(ms[2]));
            chk("model_Sd", 32'(bus.Sd), 32'(ms[3]));
            chk("model_sample", 32'(bus.sample), 32'(m_sample));
            chk("model_ovf", 32'(bus.ovf), 32'(m_ovf));
        end
    end
    task automatic tick(input logic [3:0] ci, input logic [3:0] co);
        bus.car_in = ci;
        bus.car_out = co;
        @(posedge clk);
        #1;
        bus.car_in = 0;
        bus.car_out = 0;
    endtask
    task automatic wait_sample();
        for (int k = 0; k < 16; k++) begin
            tick(0, 0);
            if (bus.sample) return;
        end
        chk("sample_timeout", 0, 1);
    endtask
    task automatic repeat_tick(input int n, input logic [3:0] ci, input logic [3:0] co);
        for (int k = 0; k < n; k++) tick(ci, co);
    endtask
    initial begin
        bus.car_in = 0;
        bus.car_out = 0;
        #22;
        chk("reset_S", 32'({bus.Sa, bus.Sb, bus.Sc, bus.Sd}), 0);
        chk("reset_sample", 32'(bus.sample), 0);
        chk("reset_ovf", 32'(bus.ovf), 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        for (int k = 1; k <= 48; k++) begin
            tick(0, 0);
            chk("idle_sample", 32'(bus.sample), 32'((k % 16) == 0));
            chk("idle_S", 32'({bus.Sa, bus.Sb, bus.Sc, bus.Sd}), 0);
        end
        chk("idle_ovf", 32'(bus.ovf), 0);
        repeat_tick(10, 4'b0001, 0);
        repeat_tick(6, 0, 0);
        chk("walk_sample", 32'(bus.sample), 1);
        chk("walk_Sa_2", 32'(bus.Sa), 2);
        chk("walk_others", 32'({bus.Sb, bus.Sc, bus.Sd}), 0);
        repeat_tick(7, 0, 4'b0001);
        repeat_tick(9, 0, 0);
        chk("walk_Sa_0", 32'(bus.Sa), 0);
        repeat_tick(3, 4'b0100, 0);
        repeat_tick(12, 0, 0);
        tick(4'b0100, 0);
        chk("edge_sample", 32'(bus.sample), 1);
        chk("edge_Sc_1", 32'(bus.Sc), 1);
        tick(4'b0010, 4'b0010);
        repeat_tick(63, 4'b0010, 0);
        tick(4'b0010, 4'b0010);
        chk("simul_ovf_b", 32'(bus.ovf), 0);
        tick(0, 4'b1000);
        wait_sample();
        chk("simul_Sb_3", 32'(bus.Sb), 3);
        chk("simul_Sd_0", 32'(bus.Sd), 0);
        repeat_tick(70, 4'b1000, 0);
        wait_sample();
        chk("sat_Sd_3", 32'(bus.Sd), 3);
        chk("sat_ovf", 32'(bus.ovf), 32'h8);
        repeat_tick(63, 0, 4'b1000);
        wait_sample();
        chk("drain_Sd_0", 32'(bus.Sd), 0);
        chk("drain_ovf", 32'(bus.ovf), 32'h8);
        repeat_tick(12, 4'b0001, 0);
        wait_sample();
        chk("mid_Sa_2", 32'(bus.Sa), 2);
        repeat_tick(9, 0, 0);
        #1;
        rst_n = 0;
        #1;
        chk("mid_S", 32'({bus.Sa, bus.Sb, bus.Sc, bus.Sd}), 0);
        chk("mid_ovf", 32'(bus.ovf), 0);
        chk("mid_sample", 32'(bus.sample), 0);
        @(posedge clk);
        #1;
        chk("mid_hold_sample", 32'(bus.sample), 0);
        rst_n = 1;
        for (int k = 1; k <= 16; k++) begin
            tick(0, 0);
            chk("mid_restart_sample", 32'(bus.sample), 32'(k == 16));
        end
        chk("mid_restart_Sa", 32'(bus.Sa), 0);
        for (int k = 0; k < 3000; k++) begin
            logic [3:0] ci, co;
            ci = 4'($urandom);
            co = 4'($urandom) & 4'($urandom);
            if (k >= 1500) co = co & 4'($urandom);
            tick(ci, co);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
